// File: rtl/equ_36_inv.sv
// Sequential restoring divider recovering G-RB from a weighted derivative: (RB_deriv << gradBitWidth) / grad.
// Define EQU36_INV_SAT_EN for saturated output; otherwise the quotient wraps to dataBitWidth bits.
module equ_36_inv #(
    parameter int dataBitWidth = 14,
    parameter int gradBitWidth = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [dataBitWidth+gradBitWidth-1:0] RB_deriv,
    input  logic [gradBitWidth-1:0]              grad,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [dataBitWidth-1:0]              G_m_RB,
    output logic                                 div_zero
);

    localparam int IW = dataBitWidth + gradBitWidth;
    localparam int QW = dataBitWidth + 2 * gradBitWidth;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);
    localparam logic [dataBitWidth-1:0] RES_MAX = {1'b0, {(dataBitWidth-1){1'b1}}};
    localparam logic [dataBitWidth-1:0] RES_MIN = {1'b1, {(dataBitWidth-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [QW-1:0]           work_q, work_d;
    logic [gradBitWidth-1:0] rem_q, rem_d;
    logic [gradBitWidth-1:0] div_q, div_d;
    logic                    neg_q, neg_d;
    logic [dataBitWidth-1:0] g_q, g_d;
    logic                    dz_q, dz_d;

    logic                    accept;
    logic [IW-1:0]           mag_in;
    logic [gradBitWidth:0]   rem_shift;
    logic                    ge;
    logic [gradBitWidth-1:0] rem_next;
    logic [dataBitWidth-1:0] div_res;
    logic [dataBitWidth-1:0] zero_res;

    assign accept = in_valid && in_ready;
    assign mag_in = RB_deriv[IW-1] ? (~RB_deriv + IW'(1)) : RB_deriv;

    // work_q shifts the dividend out of its MSB while quotient bits enter at its LSB.
    assign rem_shift = {rem_q, work_q[QW-1]};
    assign ge        = rem_shift >= {1'b0, div_q};
    assign rem_next  = ge ? (rem_shift[gradBitWidth-1:0] - div_q) : rem_shift[gradBitWidth-1:0];

`ifdef EQU36_INV_SAT_EN
    localparam int SW = QW + 1;
    localparam logic signed [QW:0] Q_MAX = SW'(2 ** (dataBitWidth - 1) - 1);
    localparam logic signed [QW:0] Q_MIN = SW'(-(2 ** (dataBitWidth - 1)));
    logic [QW:0]        q_mag;
    logic signed [QW:0] q_s;

    assign q_mag    = {1'b0, work_q[QW-2:0], ge};
    assign q_s      = neg_q ? $signed(~q_mag + SW'(1)) : $signed(q_mag);
    assign div_res  = (q_s > Q_MAX) ? RES_MAX :
                      (q_s < Q_MIN) ? RES_MIN : q_s[dataBitWidth-1:0];
    assign zero_res = RB_deriv[IW-1] ? RES_MIN : RES_MAX;
`else
    // Low bits of a two's-complement negation depend only on the low bits of the magnitude.
    logic [dataBitWidth-1:0] q_lo;

    assign q_lo     = {work_q[dataBitWidth-2:0], ge};
    assign div_res  = neg_q ? (~q_lo + dataBitWidth'(1)) : q_lo;
    assign zero_res = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (grad == '0) ? DONE : DIV;
            DIV:     if (cnt_q == LAST_ITER) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        G_m_RB    = g_q;
        div_zero  = dz_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            work_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            neg_q  <= 1'b0;
            g_q    <= '0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            work_q <= work_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            g_q    <= g_d;
            dz_q   <= dz_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        work_d = work_q;
        rem_d  = rem_q;
        div_d  = div_q;
        neg_d  = neg_q;
        g_d    = g_q;
        dz_d   = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d = {mag_in, {gradBitWidth{1'b0}}};
                    rem_d  = '0;
                    div_d  = grad;
                    neg_d  = RB_deriv[IW-1];
                    cnt_d  = '0;
                    dz_d   = (grad == '0);
                    if (grad == '0) g_d = zero_res;
                end
            end
            DIV: begin
                work_d = {work_q[QW-2:0], ge};
                rem_d  = rem_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    g_d   = div_res;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_equ_36_inv.sv
// Randomized bench for equ_36_inv: a transaction-level model predicts result value and timing each cycle.
// Expectations follow EQU36_INV_SAT_EN the same way the design does.
module tb_equ_36_inv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] RB_deriv = '0;
    logic [7:0]  grad = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [13:0] G_m_RB;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    equ_36_inv dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RB_deriv(RB_deriv), .grad(grad), .out_valid(out_valid),
        .out_ready(out_ready), .G_m_RB(G_m_RB), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer division truncating toward zero, then clamp or wrap.
    function automatic logic [13:0] ref_g(input longint rb, input longint g);
        longint q;
        if (g == 0) begin
`ifdef EQU36_INV_SAT_EN
            q = (rb >= 0) ? 8191 : -8192;
`else
            q = 0;
`endif
        end else begin
            q = (rb * 256) / g;
`ifdef EQU36_INV_SAT_EN
            if (q > 8191) q = 8191;
            else if (q < -8192) q = -8192;
`endif
        end
        return q[13:0];
    endfunction

    // Model state: a pending result, the cycle it must appear, and its value.
    bit          m_busy = 0;
    int          m_rise = 0;
    logic [13:0] m_g = '0;
    logic        m_dz = 1'b0;
    bit          m_vis;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_G_m_RB", $signed(G_m_RB), 0);
            check("rst_div_zero", div_zero, 0);
            check("rst_in_ready", in_ready, 1);
            m_busy = 0;
        end else begin
            m_vis = m_busy && (cyc >= m_rise);
            check("out_valid", out_valid, m_vis);
            check("in_ready", in_ready, !m_busy);
            if (m_vis) begin
                check("G_m_RB", $signed(G_m_RB), $signed(m_g));
                check("div_zero", div_zero, m_dz);
            end
            if (m_vis && out_ready) begin
                m_busy = 0;
            end else if (!m_busy && in_valid) begin
                m_busy = 1;
                m_rise = cyc + 1 + ((grad == 0) ? 0 : 30);
                m_g    = ref_g($signed(RB_deriv), grad);
                m_dz   = (grad == 0);
            end
        end
    end

    task automatic run_txn(input int rb, input int g, input bit bp,
                           output int lat, output int gv, output int dz);
        int n;
        bit v, r;
        lat = -1; gv = 0; dz = 0;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        RB_deriv = 22'(rb);
        grad     = 8'(g);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 300) begin
            v = out_valid;
            if (v && lat < 0) begin
                lat = n;
                gv  = $signed(G_m_RB);
                dz  = div_zero;
            end
            r = bp ? ($urandom % 3 != 0) : 1'b1;
            out_ready = r;
            if (bp) begin
                in_valid = 1'($urandom % 2);
                RB_deriv = 22'($urandom);
                grad     = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (v && r) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (lat < 0) check("result_timeout", 0, 1);
        $display("txn rb=%0d grad=%0d -> G_m_RB=%0d div_zero=%0d latency=%0d", rb, g, gv, dz, lat);
    endtask

    typedef struct { int rb; int g; int eg; int edz; int elat; } dir_t;
    dir_t dirs[$];

    initial begin
        int lat, gv, dz, n;
        int g0;
        bit seen;
        logic signed [21:0] rnd;
        int rb, g;

        dirs.push_back('{300, 64, 1200, 0, 30});
        dirs.push_back('{-7, 3, -597, 0, 30});
        dirs.push_back('{7, 3, 597, 0, 30});
        dirs.push_back('{0, 5, 0, 0, 30});
`ifdef EQU36_INV_SAT_EN
        dirs.push_back('{100000, 1, 8191, 0, 30});
        dirs.push_back('{5, 0, 8191, 1, 0});
        dirs.push_back('{-5, 0, -8192, 1, 0});
        dirs.push_back('{-2097152, 1, -8192, 0, 30});
        dirs.push_back('{2097151, 255, 8191, 0, 30});
`else
        dirs.push_back('{100000, 1, -8192, 0, 30});
        dirs.push_back('{5, 0, 0, 1, 0});
        dirs.push_back('{-5, 0, 0, 1, 0});
        dirs.push_back('{-2097152, 1, 0, 0, 30});
        dirs.push_back('{2097151, 255, -8161, 0, 30});
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("in_ready_after_rst", in_ready, 1);

        foreach (dirs[i]) begin
            run_txn(dirs[i].rb, dirs[i].g, 1'b0, lat, gv, dz);
            check("dir_G_m_RB", gv, dirs[i].eg);
            check("dir_div_zero", dz, dirs[i].edz);
            check("dir_latency", lat, dirs[i].elat);
        end

        // Backpressure in DONE with noisy inputs, then back-to-back accept.
        RB_deriv = 22'(1234); grad = 8'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("hold_reach_done", out_valid, 1);
        g0 = $signed(G_m_RB);
`ifdef EQU36_INV_SAT_EN
        check("hold_value", g0, 8191);
`else
        check("hold_value", g0, 2198);
`endif
        repeat (10) begin
            in_valid = 1'($urandom % 2);
            RB_deriv = 22'($urandom);
            grad     = 8'($urandom);
            @(posedge clk); #1;
            check("hold_G_stable", $signed(G_m_RB), g0);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1; in_valid = 1'b1; RB_deriv = 22'(300); grad = 8'd64;
        @(posedge clk); #1;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("next_accepted", in_ready, 0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("next_G_m_RB", $signed(G_m_RB), 1200);
        $display("txn rb=300 grad=64 -> G_m_RB=%0d (after held result)", $signed(G_m_RB));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Abort a division with reset at iteration 15.
        RB_deriv = 22'(300); grad = 8'd64; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_G_m_RB", $signed(G_m_RB), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_result", seen, 0);
        $display("txn reset abort during division");
        run_txn(300, 64, 1'b0, lat, gv, dz);
        check("post_abort_G_m_RB", gv, 1200);
        check("post_abort_latency", lat, 30);

        for (int i = 0; i < 150; i++) begin
            case ($urandom % 4)
                0: begin rnd = 22'($urandom); rb = rnd; end
                1: rb = int'($urandom_range(200)) - 100;
                2: case ($urandom % 3)
                       0: rb = -2097152;
                       1: rb = 2097151;
                       default: rb = 0;
                   endcase
                default: rb = int'($urandom_range(60000)) - 30000;
            endcase
            case ($urandom % 6)
                0: g = 0;
                1: g = 1;
                default: g = int'($urandom_range(255));
            endcase
            run_txn(rb, g, 1'b1, lat, gv, dz);
            check("rand_latency", lat, (g == 0) ? 0 : 30);
            check("rand_G_m_RB", gv, $signed(ref_g(rb, g)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
